// File: rtl/program_loader.sv
// program_loader: boot-time image loader that sits in front of the CPU.
// Reads a byte stream: 16-bit big-endian word count, then count big-endian
// 32-bit words. Each word is written to memory, and the CPU is released
// once the whole image is in memory.
// Optional build macro LOADER_CHECKSUM_EN: one trailing XOR checksum byte
// over the data bytes is required before the CPU is released.
//
// state   | meaning
// HDR_HI  | waiting for word-count high byte
// HDR_LO  | waiting for word-count low byte
// DATA    | assembling a 32-bit word, MSB first
// WRITE   | single-cycle memory write of the assembled word
// CHECK   | waiting for trailing checksum byte (checksum build only)
// RUN     | image loaded, CPU released (terminal)
// ERROR   | protocol fault, CPU held (terminal)
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter logic [31:0] ADDR_STEP = 32'd4,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_byte_in,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_din,
  output logic        o_cpu_run,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_words_loaded
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_RUN,
    S_ERROR
  } state_t;

  // State entered once the last word is written (or on an empty image).
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_LOAD = S_CHECK;
`else
  localparam state_t S_AFTER_LOAD = S_RUN;
`endif

  state_t      r_state;
  state_t      w_next;
  logic        r_byte_ready;
  logic        w_ready_next;
  logic [15:0] r_count;
  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic [15:0] r_words_loaded;
  logic [31:0] r_mem_addr;
  logic        w_xfer;
  logic [15:0] w_hdr_count;
  logic [15:0] w_words_inc;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_xor;
`endif

  assign w_xfer      = i_byte_valid & r_byte_ready;
  assign w_hdr_count = {r_count[15:8], i_byte_in};
  assign w_words_inc = r_words_loaded + 16'd1;

  // State register plus registered byte_ready (low in the first cycle after reset).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_HDR_HI;
      r_byte_ready <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_byte_ready <= w_ready_next;
    end
  end

  // Next-state decode and the byte_ready value for the state being entered.
  always_comb begin
    w_next       = r_state;
    w_ready_next = 1'b0;
    case (r_state)
      S_HDR_HI: if (w_xfer) w_next = S_HDR_LO;
      S_HDR_LO: begin
        if (w_xfer) begin
          if (w_hdr_count == 16'd0)                    w_next = S_AFTER_LOAD;
          else if ({16'd0, w_hdr_count} > MAX_WORDS)   w_next = S_ERROR;
          else                                         w_next = S_DATA;
        end
      end
      S_DATA:   if (w_xfer && (r_idx == 2'd3)) w_next = S_WRITE;
      S_WRITE:  w_next = (w_words_inc == r_count) ? S_AFTER_LOAD : S_DATA;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:  if (w_xfer) w_next = (i_byte_in == r_xor) ? S_RUN : S_ERROR;
`endif
      default:  w_next = r_state;
    endcase
    case (w_next)
      S_HDR_HI, S_HDR_LO, S_DATA: w_ready_next = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:                    w_ready_next = 1'b1;
`endif
      default:                    w_ready_next = 1'b0;
    endcase
  end

  // Header capture, word assembly, write bookkeeping and checksum accumulation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count        <= 16'd0;
      r_idx          <= 2'd0;
      r_word         <= 32'd0;
      r_words_loaded <= 16'd0;
      r_mem_addr     <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
      r_xor          <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_HDR_HI: if (w_xfer) r_count[15:8] <= i_byte_in;
        S_HDR_LO: if (w_xfer) r_count[7:0]  <= i_byte_in;
        S_DATA: begin
          if (w_xfer) begin
            r_word <= {r_word[23:0], i_byte_in};
            r_idx  <= r_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_xor  <= r_xor ^ i_byte_in;
`endif
          end
        end
        S_WRITE: begin
          r_words_loaded <= w_words_inc;
          r_mem_addr     <= r_mem_addr + ADDR_STEP;
        end
        default: ;
      endcase
    end
  end

  assign o_byte_ready   = r_byte_ready;
  assign o_mem_we       = (r_state == S_WRITE);
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_din      = r_word;
  assign o_cpu_run      = (r_state == S_RUN);
  assign o_done         = (r_state == S_RUN);
  assign o_error        = (r_state == S_ERROR);
  assign o_words_loaded = r_words_loaded;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage directly upstream of the multicycle CPU and its shared data/instruction memory.
- Receives a byte stream, assembles big-endian 32-bit words and writes them into memory through the memory write port.
- Holds the CPU stalled until the image is loaded, then asserts cpu_run to release it.
- The CPU's PC and memory-address mux are gated by cpu_run at the top level; memory is owned by the loader while cpu_run=0.

Parameters:
- BASE_ADDR, 0: byte address of the first word written.
- ADDR_STEP, 4: address increment per word.
- MAX_WORDS, 1024: largest accepted word count. A header above this is an error.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- byte_in, input, 8: incoming stream byte.
- byte_valid, input, 1: byte_in holds a valid byte.
- byte_ready, output, 1: loader can accept a byte. A transfer occurs when byte_valid&byte_ready at a rising edge.
- mem_we, output, 1: memory write enable, one-cycle pulse.
- mem_addr, output, 32: memory write address.
- mem_din, output, 32: memory write data.
- cpu_run, output, 1: releases the CPU. Stays 0 while loading.
- done, output, 1: image loaded successfully. Sticky.
- error, output, 1: protocol fault. Sticky until reset.
- words_loaded, output, 16: count of words written so far.

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - state=HDR_HI
  - byte_ready=0 for the reset cycle
  - mem_we=0, mem_addr=BASE_ADDR, mem_din=0
  - cpu_run=0, done=0, error=0
  - words_loaded=0, internal word count=0, byte index=0
- States: HDR_HI, HDR_LO, DATA, WRITE, CHECK (optional feature only), RUN, ERROR.
- byte_ready is registered:
  - It is 1 in HDR_HI, HDR_LO, DATA and CHECK.
  - It is 0 in WRITE, RUN and ERROR.
  - It is 0 in the first cycle after reset deassertion.
- HDR_HI: on transfer, count[15:8]=byte_in, go to HDR_LO.
- HDR_LO: on transfer, count[7:0]=byte_in. Next state:
  - count==0: go to RUN (or CHECK if the optional feature is enabled).
  - count>MAX_WORDS: go to ERROR.
  - otherwise: go to DATA.
- DATA: each transfer shifts byte_in into the assembly register, most significant byte first. Byte index runs 0..3.
  - On the 4th byte, go to WRITE.
  - The assembled word appears on mem_din in the same cycle mem_we rises.
- WRITE: exactly one cycle.
  - mem_we=1 with mem_addr=BASE_ADDR+ADDR_STEP*words_loaded.
  - On exit, words_loaded increments and mem_addr advances by ADDR_STEP. mem_we returns to 0.
  - If words_loaded (after increment) == count: go to RUN (or CHECK). Otherwise go back to DATA.
- Latency: the 4th data byte accepted at edge N gives mem_we=1 during cycle N+1. A new byte can be accepted at edge N+2.
- Bytes presented while byte_ready=0 are ignored and not consumed. byte_valid gaps of any length are tolerated in every state.
- RUN: cpu_run=1, done=1. Terminal until reset; further bytes are ignored.
- ERROR: error=1, cpu_run=0, mem_we=0. Terminal until reset.
- Address arithmetic is 32-bit modulo 2^32; wrap is not an error.
- Reset mid-load aborts immediately:
  - All outputs take their reset values asynchronously, including dropping a mem_we in flight.
  - The next load restarts at the header. Already-written memory is not cleared.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Enabled:
  - A running 8-bit XOR is kept over all data bytes (header excluded).
  - After the last WRITE, or immediately after HDR_LO when count==0, the loader enters CHECK and accepts one trailing checksum byte.
  - Match: go to RUN. Mismatch: go to ERROR.
  - The XOR accumulator resets to 0.
- Disabled:
  - No CHECK state and no accumulator.
  - Transitions that would enter CHECK go to RUN directly. No trailing byte is consumed.

Test Plan:
- Two-word load, macro off. Stream 00 02 DE AD BE EF 12 34 56 78 with continuous valid. Required response:
  - mem_we pulses twice, writing addr 0=DEADBEEF and addr 4=12345678.
  - words_loaded=2, then cpu_run=1 and done=1 one cycle after the second WRITE.
- Zero-count header 00 00 -> RUN reached with no mem_we pulse and words_loaded=0.
- Oversize header with MAX_WORDS=1024: stream 04 01 -> error=1, byte_ready=0, cpu_run stays 0, and later bytes produce no mem_we.
- Backpressure and gaps: same image as the two-word load with byte_valid toggling 1-0-0-1 randomly, plus a byte held valid during WRITE. Required response:
  - Identical memory contents to the continuous case.
  - The held byte is not consumed until byte_ready returns.
- Reset mid-load: pull rst_n low after 2 of 4 data bytes, while mem_we=1 in a second run. Required response:
  - Outputs clear within the same cycle.
  - A fresh 00 01 CA FE BA BE then writes addr 0=CAFEBABE.
- Checksum, macro on. Stream 00 01 11 22 33 44 44 -> RUN (XOR=0x44). The same stream ending 45 -> ERROR with done=0.
